// File: rtl/velocity_converter_if.sv
// Request/ready handshake and data bundle for velocity_converter.
// The requester uses the master modport and the converter uses the slave modport.
interface velocity_converter_if #(
  parameter int COORD_WIDTH = 32,
  parameter int ANGLE_WIDTH = 16
);
  logic                          request;
  logic                          ready;
  logic                          range_err;
  logic        [COORD_WIDTH-1:0] speed;
  logic signed [ANGLE_WIDTH-1:0] pitch;
  logic signed [ANGLE_WIDTH-1:0] heading;
  logic signed [COORD_WIDTH-1:0] v_x;
  logic signed [COORD_WIDTH-1:0] v_y;
  logic signed [COORD_WIDTH-1:0] v_z;

  modport master (
    output request, speed, pitch, heading,
    input  ready, range_err, v_x, v_y, v_z
  );

  modport slave (
    input  request, speed, pitch, heading,
    output ready, range_err, v_x, v_y, v_z
  );
endinterface

// File: rtl/velocity_converter.sv
// Converts (speed, pitch, heading) into signed x/y/z velocity components.
// Sequence: IDLE -> CAPTURE -> PITCH_TRIG -> PITCH_MUL -> HEAD_TRIG -> HEAD_MUL -> DONE.
// Trig uses a 91-entry quarter-sine table (Q16, 65536 = 1.0) folded by quadrant.
// Optional build macro VELOCITY_CONVERTER_ROUND_EN: products round half up instead of
// truncating toward zero; latency and interface are unchanged.
// The interface instance must be built with the same COORD_WIDTH/ANGLE_WIDTH.
module velocity_converter #(
  parameter int COORD_WIDTH = 32,
  parameter int ANGLE_WIDTH = 16,
  parameter int SPEED_MAX   = 32767
) (
  input  logic                 clk,
  input  logic                 reset,
  velocity_converter_if.slave  bus
);

  localparam int LUT_W  = 17;
  localparam int NORM_W = ANGLE_WIDTH + 2;
  localparam int PROD_W = COORD_WIDTH + LUT_W;

  localparam logic signed [NORM_W-1:0] DEG_0       = '0;
  localparam logic signed [NORM_W-1:0] DEG_360     = NORM_W'(360);
  localparam logic [COORD_WIDTH-1:0]   SPEED_LIMIT = COORD_WIDTH'(SPEED_MAX);

  // round(sin(d deg) * 65536) for d = 0..90
  localparam logic [LUT_W-1:0] SINE_LUT [0:90] = '{
        0,  1144,  2287,  3430,  4572,  5712,  6850,  7987,  9121, 10252,
    11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
    22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
    32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
    42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
    50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
    56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
    61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
    64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
    65536
  };

  typedef enum logic [2:0] {
    IDLE, CAPTURE, PITCH_TRIG, PITCH_MUL, HEAD_TRIG, HEAD_MUL, DONE
  } state_t;

  // Sign/magnitude sine and cosine of one angle, plus its out-of-range flag.
  typedef struct packed {
    logic [LUT_W-1:0] sin_mag;
    logic             sin_neg;
    logic [LUT_W-1:0] cos_mag;
    logic             cos_neg;
    logic             err;
  } trig_t;

  // Normalize once into 0..359, then fold the quadrant onto the quarter-sine table.
  function automatic trig_t angle_trig(input logic signed [ANGLE_WIDTH-1:0] a);
    logic signed [NORM_W-1:0] n;
    logic        [8:0]        d;
    trig_t                    t;
    n = {{2{a[ANGLE_WIDTH-1]}}, a};
    if (n < DEG_0)          n = n + DEG_360;
    else if (n >= DEG_360)  n = n - DEG_360;
    t     = '0;
    t.err = (n < DEG_0) || (n >= DEG_360);
    d     = t.err ? 9'd0 : n[8:0];
    if (d <= 9'd90) begin
      t.sin_mag = SINE_LUT[7'(d)];
      t.cos_mag = SINE_LUT[7'(9'd90 - d)];
    end else if (d <= 9'd180) begin
      t.sin_mag = SINE_LUT[7'(9'd180 - d)];
      t.cos_mag = SINE_LUT[7'(d - 9'd90)];
      t.cos_neg = 1'b1;
    end else if (d <= 9'd270) begin
      t.sin_mag = SINE_LUT[7'(d - 9'd180)];
      t.sin_neg = 1'b1;
      t.cos_mag = SINE_LUT[7'(9'd270 - d)];
      t.cos_neg = 1'b1;
    end else begin
      t.sin_mag = SINE_LUT[7'(9'd360 - d)];
      t.sin_neg = 1'b1;
      t.cos_mag = SINE_LUT[7'(d - 9'd270)];
    end
    return t;
  endfunction

  // Unsigned magnitude times Q16 factor; the sign is applied by the caller.
  function automatic logic [COORD_WIDTH-1:0] scale(input logic [COORD_WIDTH-1:0] m,
                                                   input logic [LUT_W-1:0]       f);
    logic [PROD_W-1:0] p;
    p = PROD_W'(m) * PROD_W'(f);
`ifdef VELOCITY_CONVERTER_ROUND_EN
    p = p + PROD_W'(32768);
`endif
    return COORD_WIDTH'(p >> 16);
  endfunction

  function automatic logic [COORD_WIDTH-1:0] apply_sign(input logic [COORD_WIDTH-1:0] mag,
                                                        input logic                   neg);
    return neg ? -mag : mag;
  endfunction

  state_t                        state, next_state;
  logic        [COORD_WIDTH-1:0] speed_q;
  logic signed [ANGLE_WIDTH-1:0] pitch_q, heading_q;
  trig_t                         pitch_t, heading_t;
  trig_t                         pitch_trig_c, heading_trig_c;
  logic        [COORD_WIDTH-1:0] v_y_mag, h_mag;
  logic signed [COORD_WIDTH-1:0] v_x_q, v_y_q, v_z_q;
  logic                          err_q;
  logic                          ready_c, range_err_c;

  assign pitch_trig_c   = angle_trig(pitch_q);
  assign heading_trig_c = angle_trig(heading_q);

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: a fixed walk through the pipeline, leaving IDLE only on request.
  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    next_state = state;
    case (state)
      IDLE:       if (bus.request) next_state = CAPTURE;
      CAPTURE:    next_state = PITCH_TRIG;
      PITCH_TRIG: next_state = PITCH_MUL;
      PITCH_MUL:  next_state = HEAD_TRIG;
      HEAD_TRIG:  next_state = HEAD_MUL;
      HEAD_MUL:   next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Output decode: ready for exactly the DONE cycle, range_err only alongside it.
  always_comb begin
    ready_c     = 1'b0;
    range_err_c = 1'b0;
    if (state == DONE) begin
      ready_c     = 1'b1;
      range_err_c = err_q;
    end
  end

  // Datapath: each stage register loads only in its own state and holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these are a handful of flops, not a memory, so all of them are cleared;
      // the sine table is a constant and needs no reset.
      speed_q   <= '0;
      pitch_q   <= '0;
      heading_q <= '0;
      pitch_t   <= '0;
      heading_t <= '0;
      v_y_mag   <= '0;
      h_mag     <= '0;
      v_x_q     <= '0;
      v_y_q     <= '0;
      v_z_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          speed_q   <= (bus.speed > SPEED_LIMIT) ? SPEED_LIMIT : bus.speed;
          pitch_q   <= bus.pitch;
          heading_q <= bus.heading;
        end
        PITCH_TRIG: pitch_t <= pitch_trig_c;
        PITCH_MUL: begin
          v_y_mag <= scale(speed_q, pitch_t.sin_mag);
          h_mag   <= scale(speed_q, pitch_t.cos_mag);
        end
        HEAD_TRIG: heading_t <= heading_trig_c;
        HEAD_MUL: begin
          err_q <= pitch_t.err | heading_t.err;
          if (pitch_t.err | heading_t.err) begin
            v_x_q <= '0;
            v_y_q <= '0;
            v_z_q <= '0;
          end else begin
            // h carries the sign of cos(pitch); v_z is the negated heading-cosine term.
            v_y_q <= apply_sign(v_y_mag, pitch_t.sin_neg);
            v_x_q <= apply_sign(scale(h_mag, heading_t.sin_mag),
                                pitch_t.cos_neg ^ heading_t.sin_neg);
            v_z_q <= apply_sign(scale(h_mag, heading_t.cos_mag),
                                ~(pitch_t.cos_neg ^ heading_t.cos_neg));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready_c;
  assign bus.range_err = range_err_c;
  assign bus.v_x       = v_x_q;
  assign bus.v_y       = v_y_q;
  assign bus.v_z       = v_z_q;

endmodule
